// File: rtl/hex_digit_counter.sv
// Prescaled up/down modulo digit counter; the prescaler exists only with HEX_DIGIT_COUNTER_PRESCALE_EN defined.
// Latency: all outputs registered, load visible one cycle later; no backpressure, en low pauses everything.
module hex_digit_counter #(
   parameter int PRESCALE = 50_000_000,
   parameter int MODULUS  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic [3:0] count,
   output logic       tick,
   output logic       tc
);

   localparam logic [3:0] MAX_VAL = 4'(MODULUS - 1);
   localparam logic [4:0] MOD_5   = 5'(MODULUS);

   if (PRESCALE < 1 || MODULUS < 2 || MODULUS > 16) begin : g_bad_param
      $error("hex_digit_counter: illegal PRESCALE or MODULUS");
   end

   logic       step_s;
   logic [3:0] count_q, count_d;
   logic       tick_q, tick_d;
   logic       tc_q, tc_d;

`ifdef HEX_DIGIT_COUNTER_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_q, presc_d;

   assign step_s = en && (presc_q == PRESC_LAST);

   always_comb begin
      presc_d = presc_q;
      if (load || step_s) begin
         presc_d = '0;
      end else if (en) begin
         presc_d = presc_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end
`else
   assign step_s = en;
`endif

   always_comb begin
      count_d = count_q;
      tick_d  = 1'b0;
      tc_d    = 1'b0;
      if (load) begin
         count_d = ({1'b0, load_val} < MOD_5) ? load_val : MAX_VAL;
      end else if (step_s) begin
         tick_d = 1'b1;
         // Wrap test uses >= so a stray out-of-range value still folds back into range.
         if (up) begin
            if (count_q >= MAX_VAL) begin
               count_d = 4'd0;
               tc_d    = 1'b1;
            end else begin
               count_d = count_q + 4'd1;
            end
         end else begin
            if (count_q == 4'd0 || count_q > MAX_VAL) begin
               count_d = MAX_VAL;
               tc_d    = 1'b1;
            end else begin
               count_d = count_q - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 4'd0;
         tick_q  <= 1'b0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= tick_d;
         tc_q    <= tc_d;
      end
   end

   assign count = count_q;
   assign tick  = tick_q;
   assign tc    = tc_q;

endmodule

// File: tb/tb_hex_digit_counter.sv
// Bench for hex_digit_counter: directed scenarios plus random traffic against a cycle-level reference model.
// Model counts enabled cycles per period; the period is PRESCALE with HEX_DIGIT_COUNTER_PRESCALE_EN, else 1.
module tb_hex_digit_counter;

   localparam int PRESCALE = 4;
   localparam int MODULUS  = 10;
`ifdef HEX_DIGIT_COUNTER_PRESCALE_EN
   localparam int PERIOD = PRESCALE;
`else
   localparam int PERIOD = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [3:0] count;
   logic       tick;
   logic       tc;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   int m_count = 0;
   int m_run   = 0;
   int m_tick  = 0;
   int m_tc    = 0;

   hex_digit_counter #(.PRESCALE(PRESCALE), .MODULUS(MODULUS)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tick     (tick),
      .tc       (tc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   // Reference: a step happens once every PERIOD enabled cycles since the last reset/load/step.
   task automatic model_edge(input logic r, input logic e, input logic u, input logic l, input logic [3:0] v);
      m_tick = 0;
      m_tc   = 0;
      if (r) begin
         m_count = 0;
         m_run   = 0;
      end else if (l) begin
         m_count = (int'(v) < MODULUS) ? int'(v) : MODULUS - 1;
         m_run   = 0;
      end else if (e) begin
         m_run++;
         if (m_run == PERIOD) begin
            m_run  = 0;
            m_tick = 1;
            if (u) begin
               m_tc    = (m_count == MODULUS - 1) ? 1 : 0;
               m_count = (m_count + 1) % MODULUS;
            end else begin
               m_tc    = (m_count == 0) ? 1 : 0;
               m_count = (m_count + MODULUS - 1) % MODULUS;
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic e, input logic u, input logic l, input logic [3:0] v);
      rst      = r;
      en       = e;
      up       = u;
      load     = l;
      load_val = v;
      @(posedge clk);
      cyc++;
      model_edge(r, e, u, l, v);
      #1;
      chk("count", int'(count), m_count);
      chk("tick", int'(tick), m_tick);
      chk("tc", int'(tc), m_tc);
   endtask

   initial begin
      // Reset state
      step(1, 0, 1, 0, 4'd0);
      step(1, 1, 1, 1, 4'd5);
      chk("reset_count_zero", int'(count), 0);

      // Free run upward from reset
      for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 4'd0);

      // Load 9, count up through the wrap
      step(0, 1, 1, 1, 4'd9);
      chk("load9_value", int'(count), 9);
      for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 4'd0);

      // Load 0, count down through the wrap
      step(0, 1, 0, 1, 4'd0);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 4'd0);

      // Mid-period load restarts the prescale period
      step(0, 1, 1, 0, 4'd0);
      step(0, 1, 1, 0, 4'd0);
      step(0, 1, 1, 1, 4'd7);
      chk("load7_value", int'(count), 7);
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 4'd0);

      // Out-of-range load saturates
      step(0, 0, 1, 1, 4'd12);
      chk("load12_saturate", int'(count), MODULUS - 1);
      step(0, 0, 1, 1, 4'd15);

      // Load coincident with the strobe edge
      step(0, 1, 1, 1, 4'd9);
      for (int i = 0; i < PERIOD - 1; i++) step(0, 1, 1, 0, 4'd0);
      step(0, 1, 1, 1, 4'd3);
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 4'd0);

      // Pause mid-period, then resume without restarting the prescaler
      step(0, 1, 1, 1, 4'd2);
      step(0, 1, 1, 0, 4'd0);
      step(0, 1, 0, 0, 4'd0);
      for (int i = 0; i < 10; i++) step(0, 0, i[0], 0, 4'd0);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 4'd0);

      // Reset together with load and en, mid-pulse
      step(0, 1, 1, 1, 4'd9);
      for (int i = 0; i < PERIOD; i++) step(0, 1, 1, 0, 4'd0);
      step(1, 1, 1, 1, 4'd6);
      chk("rst_over_load_count", int'(count), 0);
      chk("rst_over_load_tick", int'(tick), 0);
      chk("rst_over_load_tc", int'(tc), 0);

      // Direction flips at the boundaries
      step(0, 1, 0, 1, 4'd0);
      for (int i = 0; i < 3 * PERIOD; i++) step(0, 1, (i / PERIOD) % 2 == 1, 0, 4'd0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 19) == 0, 4'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hex_digit_counter.md
# hex_digit_counter

Prescaled, loadable up/down modulo counter producing the 4-bit digit value that drives the seven-segment decoder stage. It divides the board clock into a human-visible count rate and wraps within a configurable modulus (decimal or hex). It emits one-cycle pulses on each count step and on each wrap, so digits can be cascaded. `count` connects directly to the decoder's 4-bit input.

## Interface
- `PRESCALE`, default 50_000_000: clk cycles per count step; legal range ≥ 1.
- `MODULUS`, default 16: count range 0..MODULUS-1; legal range 2..16.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable; low freezes the prescaler and the count.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `load`  in  1  synchronous parallel load strobe.
- `load_val`  in  4  value for load.
- `count`  out  4  current digit, registered; feeds the seven-segment decoder.
- `tick`  out  1  registered one-cycle pulse on each count step.
- `tc`  out  1  registered one-cycle terminal-count pulse on each wrap.

## Operation
- Internal prescaler `presc`, width max(1, clog2(PRESCALE)), range 0..PRESCALE-1.
- Step strobe `s` (combinational, internal) = `en` && (`presc` == PRESCALE-1).
- Per-edge priority: `rst` > `load` > `s` > hold.
- `rst`: `count`=0, `presc`=0, `tick`=0, `tc`=0.
- `load`:
  - `count` <= `load_val` if `load_val` < MODULUS, else MODULUS-1 (saturate).
  - `presc` <= 0; `tick`=0; `tc`=0.
  - `load` applies regardless of `en`.
- `s` (no load): `presc` <= 0; `tick` <= 1.
  - Up: `count`==MODULUS-1 → 0 with `tc` <= 1; otherwise `count`+1 with `tc` <= 0.
  - Down: `count`==0 → MODULUS-1 with `tc` <= 1; otherwise `count`-1 with `tc` <= 0.
- `en`=1, not at terminal: `presc` <= `presc`+1; `tick`=0; `tc`=0.
- `en`=0: `presc` and `count` hold; `tick`=0; `tc`=0.
- `up` is sampled only on the strobe edge. Changing it between strobes is legal and takes effect on the next step.
- Arithmetic is 4-bit. `count` never leaves 0..MODULUS-1, including after a direction change at the boundary.

## Timing
- All outputs are registered. Reset value of every output is 0.
- `tick` and `tc` are high for exactly one cycle, coincident with the new `count` value.
- Count step latency:
  - First step after reset or load with `en` held high: `count` changes on the PRESCALE-th rising edge.
  - Thereafter: one step every PRESCALE enabled cycles.
- Load latency: `count` = loaded value one cycle after `load` is sampled high.
- Load and strobe in the same cycle: load wins; no step and no `tc`. The prescale period restarts.
- Reset mid-prescale or mid-pulse: everything is cleared on the next edge, and no pulse leaks out.
- Deasserting `en` mid-period pauses the prescaler. Reasserting `en` resumes from the held `presc` value; the prescaler is not restarted.
- PRESCALE=1: `s` = `en`, so the counter steps on every enabled cycle.

## Configuration
- `HEX_DIGIT_COUNTER_PRESCALE_EN`
  - Defined: prescaler is built as described above.
  - Undefined: no prescaler register; `s` = `en`, so one step per enabled cycle, independent of PRESCALE. Use this for fast simulation or for external tick generation with `en` driven by an upstream tick.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use PRESCALE=4, MODULUS=10, macro defined unless stated.
- Reset, then `en`=1, `up`=1: `count` 0→1 on the 4th edge, then 2 on the 8th. `tick` pulses every 4 cycles. `tc` stays 0.
- Load 4'd9, `up`=1, run 4 cycles: `count`=0 with `tc`=1 and `tick`=1 for exactly one cycle.
- Load 4'd0, `up`=0, run 4 cycles: `count`=9 with `tc`=1 for one cycle.
- Mid-period load 4'd7: `count`=7 next cycle and the prescaler restarts (next step 4 cycles later). Load 4'd12: `count`=9. Load coincident with strobe: no step, no `tc`.
- With `en` low for 10 cycles mid-period: `count` and `presc` frozen, no pulses. Assert `rst` together with `load` and `en`: all outputs 0 on the next edge.
- Macro undefined, `en`=1, `up`=1 from reset: `count` 1,2,…,9,0 on consecutive edges. `tc` high in the cycle `count` shows 0.
